// File: rtl/spi_master_loader.sv
// spi_master_loader
// Host-side SPI master (mode 0, MSB first) that drives the CNN4IC serial port.
// Sends one of three frames per Start: a full image (header 8'hA1 followed by
// the image bits), an addressed weight write (8'hB2, address, weight), or a
// result read-back (8'hC3 followed by DATAWIDTH_BUS dummy zero bits, with MISO
// captured on those bits).
//
// Ports:
//   SPI_Master_CLOCK_50         system clock
//   SPI_Master_RESET_InLow      asynchronous active-low reset
//   SPI_Master_Start_In         one-cycle frame request (honoured only in IDLE)
//   SPI_Master_Cmd_InBUS        00 image, 01 weight, 10 read, 11 reserved (ignored)
//   SPI_Master_Image_InBUS      image bits (sent MSB first)
//   SPI_Master_Weight_InBUS     weight value
//   SPI_Master_Addr_InBUS       weight address
//   SPI_Master_MISO_In          serial data from the device
//   SPI_Master_SCLK_Out         SPI clock, idles low
//   SPI_Master_SS_N_Out         slave select, active low
//   SPI_Master_MOSI_Out         serial data to the device
//   SPI_Master_Busy_Out         high while a frame is in progress
//   SPI_Master_Done_Out         one-cycle pulse at frame end
//   SPI_Master_ReadData_OutBUS  last read-back byte
module spi_master_loader #(
    parameter int IMAGEWIDTH    = 784,
    parameter int DATAWIDTH_BUS = 8,
    parameter int ADDRESS_WIDTH = 16,
    parameter int CLKDIV        = 4,
    parameter int CS_GUARD      = 2
) (
    input  logic                     SPI_Master_CLOCK_50,
    input  logic                     SPI_Master_RESET_InLow,
    input  logic                     SPI_Master_Start_In,
    input  logic [1:0]               SPI_Master_Cmd_InBUS,
    input  logic [IMAGEWIDTH-1:0]    SPI_Master_Image_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] SPI_Master_Weight_InBUS,
    input  logic [ADDRESS_WIDTH-1:0] SPI_Master_Addr_InBUS,
    input  logic                     SPI_Master_MISO_In,
    output logic                     SPI_Master_SCLK_Out,
    output logic                     SPI_Master_SS_N_Out,
    output logic                     SPI_Master_MOSI_Out,
    output logic                     SPI_Master_Busy_Out,
    output logic                     SPI_Master_Done_Out,
    output logic [DATAWIDTH_BUS-1:0] SPI_Master_ReadData_OutBUS
);

    localparam int SR_W     = IMAGEWIDTH + 8;
    localparam int CNT_W    = $clog2(IMAGEWIDTH + 9);
    localparam int PH_DIV_W = $clog2(CLKDIV + 1);
    localparam int PH_GRD_W = $clog2(CS_GUARD + 1);
    localparam int PH_W     = (PH_DIV_W > PH_GRD_W) ? PH_DIV_W : PH_GRD_W;
    localparam int WR_BITS  = 8 + ADDRESS_WIDTH + DATAWIDTH_BUS;
    localparam int RD_BITS  = 8 + DATAWIDTH_BUS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HI,
        S_LO,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                   state, state_nx;
    logic [PH_W-1:0]          phase_cnt;
    logic [CNT_W-1:0]         bit_cnt;     // bits whose high phase is still to come
    logic [SR_W-1:0]          shreg;
    logic [DATAWIDTH_BUS-1:0] rx_sh;
    logic                     is_read;
    logic [DATAWIDTH_BUS-1:0] read_data;

    logic                     accept;
    logic                     phase_last;
    logic [SR_W-1:0]          frame_load;
    logic [CNT_W-1:0]         n_load;

    assign accept     = (state == S_IDLE) && SPI_Master_Start_In && (SPI_Master_Cmd_InBUS != 2'b11);
    assign phase_last = (phase_cnt == '0);

    // Frames are left-aligned so the header MSB is always shreg[SR_W-1];
    // shorter frames are padded with zeros on the right.
    always_comb begin
        frame_load = '0;
        n_load     = '0;
        case (SPI_Master_Cmd_InBUS)
            2'b00: begin
                frame_load = {8'hA1, SPI_Master_Image_InBUS};
                n_load     = CNT_W'(SR_W);
            end
            2'b01: begin
                frame_load[SR_W-1 -: WR_BITS] = {8'hB2, SPI_Master_Addr_InBUS, SPI_Master_Weight_InBUS};
                n_load     = CNT_W'(WR_BITS);
            end
            2'b10: begin
                frame_load[SR_W-1 -: 8] = 8'hC3;
                n_load     = CNT_W'(RD_BITS);
            end
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept)     state_nx = S_SETUP;
            S_SETUP: if (phase_last) state_nx = S_HI;
            S_HI:    if (phase_last) state_nx = S_LO;
            S_LO:    if (phase_last) state_nx = (bit_cnt == '0) ? S_HOLD : S_HI;
            S_HOLD:  if (phase_last) state_nx = S_DONE;
            S_DONE:                  state_nx = S_IDLE;
            default:                 state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge SPI_Master_CLOCK_50 or negedge SPI_Master_RESET_InLow) begin
        if (!SPI_Master_RESET_InLow) state <= S_IDLE;
        else                         state <= state_nx;
    end

    always_ff @(posedge SPI_Master_CLOCK_50 or negedge SPI_Master_RESET_InLow) begin
        if (!SPI_Master_RESET_InLow) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_sh     <= '0;
            is_read   <= 1'b0;
            read_data <= '0;
        end else begin
            // Phase counter reloads on every state change and counts down to 0
            if (state_nx != state) begin
                case (state_nx)
                    S_SETUP, S_HOLD: phase_cnt <= PH_W'(CS_GUARD - 1);
                    S_HI, S_LO:      phase_cnt <= PH_W'(CLKDIV - 1);
                    default:         phase_cnt <= '0;
                endcase
            end else if (!phase_last) begin
                phase_cnt <= phase_cnt - 1'b1;
            end

            // Inputs are captured once; later input changes cannot disturb the frame
            if (accept) begin
                shreg   <= frame_load;
                bit_cnt <= n_load;
                is_read <= (SPI_Master_Cmd_InBUS == 2'b10);
            end

            // SCLK fall: next bit onto MOSI
            if (state == S_HI && state_nx == S_LO) begin
                shreg   <= {shreg[SR_W-2:0], 1'b0};
                bit_cnt <= bit_cnt - 1'b1;
            end

            // SCLK rise: MISO has been stable since the preceding fall
            if (state_nx == S_HI && state != S_HI)
                rx_sh <= {rx_sh[DATAWIDTH_BUS-2:0], SPI_Master_MISO_In};

            // rx_sh then holds the last DATAWIDTH_BUS samples, oldest as MSB
            if (state == S_HOLD && state_nx == S_DONE && is_read)
                read_data <= rx_sh;
        end
    end

    assign SPI_Master_Busy_Out        = (state == S_SETUP) || (state == S_HI) ||
                                        (state == S_LO)    || (state == S_HOLD);
    assign SPI_Master_SS_N_Out        = !SPI_Master_Busy_Out;
    assign SPI_Master_SCLK_Out        = (state == S_HI);
    assign SPI_Master_MOSI_Out        = ((state == S_SETUP) || (state == S_HI) || (state == S_LO))
                                        ? shreg[SR_W-1] : 1'b0;
    assign SPI_Master_Done_Out        = (state == S_DONE);
    assign SPI_Master_ReadData_OutBUS = read_data;

endmodule

// File: tb/tb_spi_master_loader.sv
// Scoreboard bench for spi_master_loader (CLKDIV=2, CS_GUARD=2).
// Stimulus pushes the expected frame (bits on MOSI, rise count, Busy length,
// ReadData) into a queue; the monitor captures MOSI on every SCLK rise and
// pops/compares at each Done pulse. A small device model shifts a 16-bit
// pattern out on MISO, changing on SCLK falls.
module tb_spi_master_loader;

    localparam int IW = 784;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic [IW-1:0] image = '0;
    logic [7:0]    weight = '0;
    logic [15:0]   addr = '0;
    logic          miso = 1'b0;
    logic          sclk, ss_n, mosi, busy, done;
    logic [7:0]    rd;

    always #5 clk = ~clk;

    spi_master_loader #(
        .IMAGEWIDTH(IW), .DATAWIDTH_BUS(8), .ADDRESS_WIDTH(16), .CLKDIV(2), .CS_GUARD(2)
    ) dut (
        .SPI_Master_CLOCK_50       (clk),
        .SPI_Master_RESET_InLow    (rst_n),
        .SPI_Master_Start_In       (start),
        .SPI_Master_Cmd_InBUS      (cmd),
        .SPI_Master_Image_InBUS    (image),
        .SPI_Master_Weight_InBUS   (weight),
        .SPI_Master_Addr_InBUS     (addr),
        .SPI_Master_MISO_In        (miso),
        .SPI_Master_SCLK_Out       (sclk),
        .SPI_Master_SS_N_Out       (ss_n),
        .SPI_Master_MOSI_Out       (mosi),
        .SPI_Master_Busy_Out       (busy),
        .SPI_Master_Done_Out       (done),
        .SPI_Master_ReadData_OutBUS(rd)
    );

    typedef struct {
        int           n;
        logic [799:0] bits;
        int           busy_len;
        logic [7:0]   rd;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Device model: MISO changes on SS_N fall and on each SCLK fall
    logic [15:0] miso_pat = '0;
    int          dev_cnt = 0;
    logic        dev_act = 1'b0;
    always @(negedge ss_n or posedge ss_n or negedge sclk) begin
        if (ss_n) begin
            dev_act = 1'b0;
            miso    = 1'b0;
        end else begin
            if (!dev_act) begin
                dev_act = 1'b1;
                dev_cnt = 0;
            end else begin
                dev_cnt++;
            end
            miso = (dev_cnt < 16) ? miso_pat[15 - dev_cnt] : 1'b0;
        end
    end

    // Monitor
    int           busy_cnt = 0, rises = 0, done_cnt = 0, ss_falls = 0, ss_viol = 0;
    logic [799:0] cap = '0;
    logic         prev_busy = 1'b0, prev_sclk = 1'b0, prev_ss = 1'b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
            prev_sclk = 1'b0;
            prev_ss   = 1'b1;
        end else begin
            if (busy && !prev_busy) begin
                busy_cnt = 0;
                rises    = 0;
                cap      = '0;
            end
            if (busy) busy_cnt++;
            if (ss_n !== !busy) ss_viol++;
            if (!ss_n && prev_ss) ss_falls++;
            if (sclk && !prev_sclk) begin
                cap = {cap[798:0], mosi};
                rises++;
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got a Done pulse, expected none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rise_count", 64'(rises), 64'(e.n));
                    chk("busy_len", 64'(busy_cnt), 64'(e.busy_len));
                    chk("ss_n_at_done", 64'(ss_n), 64'd1);
                    chk("read_data_at_done", 64'(rd), 64'(e.rd));
                    n_cmp++;
                    if (cap !== e.bits) begin
                        n_err++;
                        $display("FAIL frame_bits: got %0h, expected %0h", cap, e.bits);
                    end
                end
            end
            prev_busy = busy;
            prev_sclk = sclk;
            prev_ss   = ss_n;
        end
    end

    task automatic push_exp(input int n, input logic [799:0] bits, input int bl, input logic [7:0] r);
        exp_t e;
        e.n = n; e.bits = bits; e.busy_len = bl; e.rd = r;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [1:0] c);
        @(posedge clk); #1;
        cmd   = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no Done in %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    initial begin
        logic [799:0] bv;
        logic [IW-1:0] img;
        int bad, sclk_edges, d0, f0;
        logic last_sclk;

        // 1: reset held with Start high
        #2 rst_n = 1'b0;
        start = 1'b1;
        bad = 0; sclk_edges = 0; last_sclk = sclk;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ss_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || rd !== 8'h00) bad++;
            if (sclk !== last_sclk) sclk_edges++;
            last_sclk = sclk;
        end
        chk("reset_outputs", 64'(bad), 64'd0);
        chk("reset_sclk_edges", 64'(sclk_edges), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        wait_cycles(3);

        // 2: weight frame, 32 bits, Busy 2*2 + 2*2*32 = 132
        addr = 16'h0123; weight = 8'h7F;
        bv = '0; bv[31:0] = 32'hB201237F;
        push_exp(32, bv, 132, 8'h00);
        pulse_start(2'b01);
        wait_done("weight1", 400);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);

        // 3: image frame, first and last image bits set, Busy 4 + 4*792 = 3172
        img = '0; img[IW-1] = 1'b1; img[0] = 1'b1;
        image = img;
        bv = '0; bv[791:0] = {8'hA1, img};
        push_exp(792, bv, 3172, 8'h00);
        pulse_start(2'b00);
        image = '0;                     // frame already captured
        wait_done("image1", 5000);

        // 4: read frame, device returns 8'h07 on the data byte
        miso_pat = 16'h0007;
        bv = '0; bv[15:0] = 16'hC300;
        push_exp(16, bv, 68, 8'h07);
        pulse_start(2'b10);
        wait_done("read1", 300);
        wait_cycles(5);
        chk("read_data_held", 64'(rd), 64'h07);
        miso_pat = 16'h0000;
        addr = 16'hA55A; weight = 8'h3C;
        bv = '0; bv[31:0] = 32'hB2A55A3C;
        push_exp(32, bv, 132, 8'h07);
        pulse_start(2'b01);
        wait_done("weight2", 400);

        // 5a: reserved command is ignored
        d0 = done_cnt; f0 = ss_falls;
        pulse_start(2'b11);
        wait_cycles(40);
        chk("rsvd_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rsvd_no_ss_fall", 64'(ss_falls - f0), 64'd0);

        // 5b: Start mid-frame is ignored
        d0 = done_cnt; f0 = ss_falls;
        addr = 16'h0F0F; weight = 8'hE1;
        bv = '0; bv[31:0] = 32'hB20F0FE1;
        push_exp(32, bv, 132, 8'h07);
        pulse_start(2'b01);
        wait_cycles(20);
        addr = 16'h1111; weight = 8'h22;
        pulse_start(2'b00);
        wait_done("weight3", 400);
        wait_cycles(200);
        chk("midstart_one_done", 64'(done_cnt - d0), 64'd1);
        chk("midstart_one_frame", 64'(ss_falls - f0), 64'd1);

        // 6: reset after the 300th rise of an image frame
        image = {IW{1'b1}};
        bv = '0;
        push_exp(792, bv, 3172, 8'h07);
        pulse_start(2'b00);
        for (int i = 0; i < 2000 && rises < 300; i++) @(posedge clk);
        chk("reach_rise_300", 64'(rises >= 300), 64'd1);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ss_n", 64'(ss_n), 64'd1);
        chk("async_rst_sclk", 64'(sclk), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_read_data", 64'(rd), 64'h00);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        wait_cycles(3);
        #1 rst_n = 1'b1;
        wait_cycles(20);
        chk("aborted_no_done", 64'(done_cnt - d0), 64'd0);
        addr = 16'hFFFF; weight = 8'h01;
        bv = '0; bv[31:0] = 32'hB2FFFF01;
        push_exp(32, bv, 132, 8'h00);
        pulse_start(2'b01);
        wait_done("weight4", 400);

        wait_cycles(5);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("ss_within_busy", 64'(ss_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_loader.md
Name: spi_master_loader

Overview:
- Host-side SPI master that drives the CNN4IC serial port (SCLK, SS_N, MOSI; samples MISO).
- Sends three frame types: a full 784-bit image, a single addressed weight write, and a one-byte result read-back of the predicted digit.
- Sits in the host/test-harness FPGA fabric and drives a CNN4IC device.
- One frame per Start; Busy/Done handshake towards the host logic.

Parameters:
- IMAGEWIDTH, 784, image bits per image frame.
- DATAWIDTH_BUS, 8, weight word width and read-back width.
- ADDRESS_WIDTH, 16, weight address width.
- CLKDIV, 4, SCLK half-period in system clocks; must be >= 1.
- CS_GUARD, 2, system clocks between SS_N fall and the first SCLK rise; also between the last SCLK fall and SS_N rise; must be >= 1.

Ports:
- SPI_Master_CLOCK_50  in  1  system clock.
- SPI_Master_RESET_InLow  in  1  asynchronous active-low reset.
- SPI_Master_Start_In  in  1  one-cycle frame request.
- SPI_Master_Cmd_InBUS  in  2  frame type: 00 image, 01 weight, 10 read, 11 reserved.
- SPI_Master_Image_InBUS  in  IMAGEWIDTH  image bits to send.
- SPI_Master_Weight_InBUS  in  DATAWIDTH_BUS  weight value to send.
- SPI_Master_Addr_InBUS  in  ADDRESS_WIDTH  weight address to send.
- SPI_Master_MISO_In  in  1  serial data from the device.
- SPI_Master_SCLK_Out  out  1  SPI clock; idles low.
- SPI_Master_SS_N_Out  out  1  slave select, active low.
- SPI_Master_MOSI_Out  out  1  serial data to the device.
- SPI_Master_Busy_Out  out  1  high while a frame is in progress.
- SPI_Master_Done_Out  out  1  one-cycle pulse at frame end.
- SPI_Master_ReadData_OutBUS  out  DATAWIDTH_BUS  last read-back byte.

Behaviour:

Reset (asynchronous, takes effect immediately, including mid-frame):
- SS_N=1, SCLK=0, MOSI=0, Busy=0, Done=0, ReadData=0.
- FSM goes to IDLE; a partial frame is abandoned and produces no Done.

SPI timing:
- SPI mode 0, MSB first.
- MOSI changes only while SCLK is low; the device samples on the SCLK rise.
- The master samples MISO on each SCLK rise.

Frame formats (header byte first):
- Image: 8'hA1, then Image[IMAGEWIDTH-1:0] MSB first; N = 8+IMAGEWIDTH (792).
- Weight: 8'hB2, then Addr[ADDRESS_WIDTH-1:0], then Weight[DATAWIDTH_BUS-1:0]; N = 32.
- Read: 8'hC3, then 8 dummy zero bits; N = 16.

Start acceptance:
- Start is accepted only in IDLE with Cmd != 11.
- Cmd = 11, or Start while Busy, is ignored silently: no SPI activity, no Done.
- On acceptance the frame is loaded into a left-aligned shift register of width IMAGEWIDTH+8, and bit count N is loaded.
- Later changes on the Image/Weight/Addr/Cmd inputs do not affect the frame in flight.

FSM states:
- IDLE: SS_N=1, SCLK=0, Busy=0. Goes to SETUP on an accepted Start.
- SETUP (CS_GUARD cycles):
  - Entered the cycle after Start; SS_N=0 and Busy=1 from this cycle.
  - MOSI = frame MSB; SCLK=0.
- SHIFT_HI (CLKDIV cycles):
  - SCLK=1; MISO is sampled on entry.
  - Goes to SHIFT_LO.
- SHIFT_LO (CLKDIV cycles):
  - SCLK=0; the shift register advances and MOSI presents the next bit on entry.
  - Goes to SHIFT_HI while bits remain.
  - After the N-th bit's low phase, goes to HOLD.
- HOLD (CS_GUARD cycles): SCLK=0, SS_N=0, MOSI=0.
- DONE (1 cycle):
  - SS_N=1, Busy=0, Done=1.
  - For a read frame, ReadData is loaded with the 8 MISO bits sampled on the last 8 rises, first sampled = MSB.
  - Goes to IDLE; a Start in this cycle is ignored.

Timing rules:
- Busy is high for exactly 2*CS_GUARD + 2*CLKDIV*N cycles.
- Exactly N SCLK rising edges per frame.
- Image and weight frames leave ReadData unchanged.

Internals:
- Bit counter width: $clog2(IMAGEWIDTH+9).
- Phase counter width: $clog2(CLKDIV+1), shared for CS_GUARD where it fits; otherwise max of both.

Test Plan:
1. Assert reset low with Start=1 held -> SS_N=1, SCLK=0, MOSI=0, Busy=0, Done=0, ReadData=8'h00 throughout; no SCLK edge.
2. CLKDIV=2, CS_GUARD=2; weight frame, Addr=16'h0123, Weight=8'h7F -> 32 rises; bits captured on rises = 32'hB201237F; Busy high 132 cycles; one Done pulse with SS_N=1 that cycle.
3. Image frame, Image[783]=1, Image[0]=1, rest 0 -> 792 rises; first byte 8'hA1; bit 9 = 1; bits 10..790 = 0; bit 792 = 1; SS_N low only within Busy.
4. Read frame, device model drives MISO=8'h07 MSB-first on the data byte -> ReadData=8'h07 valid in the Done cycle and held afterwards; a subsequent weight frame leaves ReadData=8'h07.
5. Start with Cmd=2'b11 -> no SS_N fall, no Done. Start pulsed mid-weight-frame -> ignored; exactly one frame, one Done.
6. Reset asserted after the 300th rise of an image frame -> SS_N=1 and SCLK=0 without waiting for a clock edge; no Done. After release, a weight frame Addr=16'hFFFF, Weight=8'h01 -> 32'hB2FFFF01 captured correctly.
